sech2_lut_arbiter: RTL and testbench
====================================

# sech2_lut_arbiter

Packet-level round-robin arbiter that shares one single-channel Sech2Lutram instance between several independent AXI-Stream requesters in the KAN activation datapath. It grants the LUT input to one requester per packet (tlast-delimited) and records the grant order in a route FIFO. It then steers the LUT's in-order result packets back to the originating requester. No ID/dest sideband through the LUT is required.

## Interface
- DATA_WIDTH_DATA, 16, requester/LUT input sample width
- DATA_WIDTH_RSLT, 16, LUT result / requester output width
- REQUESTERS, 4, number of requester ports (2..16)
- ROUTE_DEPTH, 4, route FIFO entries (power of two ≥2), max packets in flight inside the LUT
- IDX_WIDTH, $clog2(REQUESTERS), requester index width (derived)

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- s_axis_req_tdata  in  REQUESTERS*DATA_WIDTH_DATA  requester samples, lane k = requester k
- s_axis_req_tlast  in  REQUESTERS  end of packet per requester
- s_axis_req_tvalid  in  REQUESTERS
- s_axis_req_tready  out  REQUESTERS
- m_axis_lut_tdata  out  DATA_WIDTH_DATA  to LUT s_axis_0_tdata
- m_axis_lut_tlast  out  1
- m_axis_lut_tvalid  out  1
- m_axis_lut_tready  in  1
- s_axis_lut_tdata  in  DATA_WIDTH_RSLT  from LUT m_axis_0_tdata
- s_axis_lut_tlast  in  1
- s_axis_lut_tvalid  in  1
- s_axis_lut_tready  out  1
- m_axis_rslt_tdata  out  REQUESTERS*DATA_WIDTH_RSLT  results, lane k = requester k
- m_axis_rslt_tlast  out  REQUESTERS
- m_axis_rslt_tvalid  out  REQUESTERS
- m_axis_rslt_tready  in  REQUESTERS
- busy  out  1  high in BUSY state or route FIFO non-empty

## Operation
- Issue FSM states: IDLE, BUSY. Registers: grant (IDX_WIDTH), rr_ptr (IDX_WIDTH), route FIFO (ROUTE_DEPTH × IDX_WIDTH, count register).
- IDLE: if any s_axis_req_tvalid and route FIFO not full (registered count < ROUTE_DEPTH), grant = first k with tvalid searching rr_ptr, rr_ptr+1, … modulo REQUESTERS. Push grant into route FIFO, go BUSY. Otherwise stay IDLE.
- BUSY: m_axis_lut_{tdata,tlast,tvalid} = lane grant of requester inputs. s_axis_req_tready[grant] = m_axis_lut_tready. All other treadys are 0. On handshake with tlast: rr_ptr = grant+1 (wrap to 0 at REQUESTERS), go IDLE.
- IDLE: m_axis_lut_tvalid = 0, all s_axis_req_tready = 0.
- Return path (combinational, FIFO head h):
  - m_axis_rslt_tvalid[k] = s_axis_lut_tvalid & nonempty & (h==k).
  - s_axis_lut_tready = nonempty & m_axis_rslt_tready[h].
  - tdata/tlast are broadcast to all lanes.
  - Pop on return handshake with s_axis_lut_tlast.
- Route FIFO empty: s_axis_lut_tready = 0 (LUT stalls; no result dropped).
- Full check uses the registered count. A pop in the same cycle does not unblock a push.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Requester deasserting tvalid mid-packet in BUSY: grant holds until that requester's tlast handshake. Single-beat packets (tlast on first beat) are legal.
- Reset mid-operation: FSM to IDLE, rr_ptr = 0, FIFO cleared. In-flight LUT data is not tracked; the LUT shares the same rst.

## Timing
- Reset values: s_axis_req_tready = 0, m_axis_lut_tvalid = 0, m_axis_lut_tlast = 0, s_axis_lut_tready = 0, m_axis_rslt_tvalid = 0, busy = 0. Data outputs are don't-care.
- Grant latency: one cycle. Request visible in IDLE at edge n means the first beat may transfer at edge n+1.
- One idle bubble cycle between consecutive packets. Throughput within a packet is 1 beat/cycle.
- Forward and return paths are combinational through the block (no added data latency). tready→tvalid is not looped within the block.

## Structure
- Shared package kan_arb_pkg: requester index type width function (clog2), FSM state encoding (IDLE=0, BUSY=1).
- One natural sub-module: route_fifo (synchronous, registered count, full/empty flags, push/pop same cycle). The round-robin search is inline.

## Test plan
- Reset: hold rst 3 cycles with all requesters valid → all treadys 0, m_axis_lut_tvalid 0, busy 0. First grant after release goes to requester 0.
- Round robin: all 4 requesters continuously send 2-beat packets, LUT tready=1 → grant order 0,1,2,3,0…, one bubble between packets. Results returned to the matching lanes in the same order.
- Sparse requests: only requesters 1 and 3 valid, rr_ptr=2 → grant 3 then 1. Packet data 0x0040..0x0043 reaches LUT unmodified.
- Route full: ROUTE_DEPTH=4, LUT output held (result tready=0) → exactly 4 packets are issued, then FSM stays IDLE. A pop in the same cycle still blocks the push; issue resumes the cycle after the first result tlast pop.
- Backpressure: m_axis_rslt_tready[2]=0 while head=2 → s_axis_lut_tready=0 and the LUT stalls. Other lanes stay tvalid=0. Releasing the ready delivers the result beats intact.
- Mid-packet stall and reset: requester 1 drops tvalid mid-packet → no other grant occurs. Asserting rst during BUSY → next cycle IDLE, FIFO empty, rr_ptr 0.

Source files
------------

// File: rtl/kan_arb_pkg.sv
// Shared definitions for the Sech2 LUT requester arbiter.
// Provides the issue FSM state encoding and the requester index width helper.
package kan_arb_pkg;

  // Issue FSM: IDLE selects the next requester, BUSY forwards its packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Index width for n requesters; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sech2_lut_arbiter_route_fifo.sv
// Route FIFO: remembers which requester owns each packet in flight inside the LUT.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push, push_data  write one requester index (ignored when full)
//   pop              retire the head entry (ignored when empty)
//   head             index at the FIFO head, valid when !empty
//   full, empty      status from the registered count
module sech2_lut_arbiter_route_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Status comes only from the registered count, so a same-cycle pop never frees room for a push.
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sech2_lut_arbiter.sv
// Packet-level round-robin arbiter sharing one Sech2 LUT channel among several
// AXI-Stream requesters. Each tlast-delimited packet is granted whole; the grant
// order is recorded in a route FIFO and used to steer the LUT's in-order results
// back to the originating requester.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_req_*             requester inputs, lane k = requester k
//   m_axis_lut_*             granted requester stream into the LUT
//   s_axis_lut_*             LUT result stream
//   m_axis_rslt_*            results per requester, data/last broadcast to all lanes
//   busy                     packet being issued or results still owed
module sech2_lut_arbiter
  import kan_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_DATA = 16,
  parameter int unsigned DATA_WIDTH_RSLT = 16,
  parameter int unsigned REQUESTERS      = 4,
  parameter int unsigned ROUTE_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQUESTERS*DATA_WIDTH_DATA-1:0] s_axis_req_tdata,
  input  logic [REQUESTERS-1:0]                 s_axis_req_tlast,
  input  logic [REQUESTERS-1:0]                 s_axis_req_tvalid,
  output logic [REQUESTERS-1:0]                 s_axis_req_tready,
  output logic [DATA_WIDTH_DATA-1:0]            m_axis_lut_tdata,
  output logic                                  m_axis_lut_tlast,
  output logic                                  m_axis_lut_tvalid,
  input  logic                                  m_axis_lut_tready,
  input  logic [DATA_WIDTH_RSLT-1:0]            s_axis_lut_tdata,
  input  logic                                  s_axis_lut_tlast,
  input  logic                                  s_axis_lut_tvalid,
  output logic                                  s_axis_lut_tready,
  output logic [REQUESTERS*DATA_WIDTH_RSLT-1:0] m_axis_rslt_tdata,
  output logic [REQUESTERS-1:0]                 m_axis_rslt_tlast,
  output logic [REQUESTERS-1:0]                 m_axis_rslt_tvalid,
  input  logic [REQUESTERS-1:0]                 m_axis_rslt_tready,
  output logic                                  busy
);

  localparam int unsigned IDX_WIDTH = idx_width(REQUESTERS);
  localparam int unsigned CW        = IDX_WIDTH + 1;

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] rr_pick;
  logic [CW-1:0]        cand;
  logic                 rr_found;
  logic [IDX_WIDTH-1:0] route_head;
  logic                 route_full;
  logic                 route_empty;
  logic                 push;
  logic                 pop;
  logic                 sel_valid;
  logic                 sel_last;
  logic                 lut_fwd_hs;

  // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... modulo REQUESTERS.
  always_comb begin
    rr_pick  = rr_ptr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(REQUESTERS)) cand = cand - CW'(REQUESTERS);
      if (!rr_found && s_axis_req_tvalid[cand[IDX_WIDTH-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = cand[IDX_WIDTH-1:0];
      end
    end
  end

  assign sel_valid  = s_axis_req_tvalid[grant_q];
  assign sel_last   = s_axis_req_tlast[grant_q];
  assign lut_fwd_hs = (state_q == ST_BUSY) & sel_valid & m_axis_lut_tready;

  // Issue FSM next state: grant and push in IDLE, hold the grant until its tlast handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rr_found && !route_full) begin
          grant_d = rr_pick;
          push    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (lut_fwd_hs && sel_last) begin
          rr_ptr_d = (grant_q == IDX_WIDTH'(REQUESTERS - 1)) ? '0 : grant_q + IDX_WIDTH'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Forward path: the granted lane passes straight through while BUSY.
  always_comb begin
    m_axis_lut_tdata  = s_axis_req_tdata[grant_q*DATA_WIDTH_DATA +: DATA_WIDTH_DATA];
    m_axis_lut_tvalid = 1'b0;
    m_axis_lut_tlast  = 1'b0;
    s_axis_req_tready = '0;
    if (state_q == ST_BUSY) begin
      m_axis_lut_tvalid          = sel_valid;
      m_axis_lut_tlast           = sel_last;
      s_axis_req_tready[grant_q] = m_axis_lut_tready;
    end
  end

  // Return path: the FIFO head owns the current result packet; with no owner the LUT stalls.
  always_comb begin
    m_axis_rslt_tvalid = '0;
    s_axis_lut_tready  = 1'b0;
    if (!route_empty) begin
      m_axis_rslt_tvalid[route_head] = s_axis_lut_tvalid;
      s_axis_lut_tready              = m_axis_rslt_tready[route_head];
    end
  end

  assign m_axis_rslt_tdata = {REQUESTERS{s_axis_lut_tdata}};
  assign m_axis_rslt_tlast = {REQUESTERS{s_axis_lut_tlast}};
  assign pop               = s_axis_lut_tvalid & s_axis_lut_tready & s_axis_lut_tlast;
  assign busy              = (state_q == ST_BUSY) | ~route_empty;

  sech2_lut_arbiter_route_fifo #(
    .DEPTH (ROUTE_DEPTH),
    .WIDTH (IDX_WIDTH)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (grant_d),
    .pop       (pop),
    .head      (route_head),
    .full      (route_full),
    .empty     (route_empty)
  );

endmodule

// File: tb/tb_sech2_lut_arbiter.sv
// Scoreboard bench for sech2_lut_arbiter with a behavioural in-order LUT (result = ~sample).
module tb_sech2_lut_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*DW-1:0]  s_axis_req_tdata = '0;
  logic [NR-1:0]     s_axis_req_tlast = '0;
  logic [NR-1:0]     s_axis_req_tvalid = '0;
  logic [NR-1:0]     s_axis_req_tready;
  logic [DW-1:0]     m_axis_lut_tdata;
  logic              m_axis_lut_tlast;
  logic              m_axis_lut_tvalid;
  logic              m_axis_lut_tready = 1'b1;
  logic [DW-1:0]     s_axis_lut_tdata = '0;
  logic              s_axis_lut_tlast = 1'b0;
  logic              s_axis_lut_tvalid = 1'b0;
  logic              s_axis_lut_tready;
  logic [NR*DW-1:0]  m_axis_rslt_tdata;
  logic [NR-1:0]     m_axis_rslt_tlast;
  logic [NR-1:0]     m_axis_rslt_tvalid;
  logic [NR-1:0]     m_axis_rslt_tready = 4'hF;
  logic              busy;

  sech2_lut_arbiter #(
    .DATA_WIDTH_DATA (DW),
    .DATA_WIDTH_RSLT (DW),
    .REQUESTERS      (NR),
    .ROUTE_DEPTH     (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_req_tdata   (s_axis_req_tdata),
    .s_axis_req_tlast   (s_axis_req_tlast),
    .s_axis_req_tvalid  (s_axis_req_tvalid),
    .s_axis_req_tready  (s_axis_req_tready),
    .m_axis_lut_tdata   (m_axis_lut_tdata),
    .m_axis_lut_tlast   (m_axis_lut_tlast),
    .m_axis_lut_tvalid  (m_axis_lut_tvalid),
    .m_axis_lut_tready  (m_axis_lut_tready),
    .s_axis_lut_tdata   (s_axis_lut_tdata),
    .s_axis_lut_tlast   (s_axis_lut_tlast),
    .s_axis_lut_tvalid  (s_axis_lut_tvalid),
    .s_axis_lut_tready  (s_axis_lut_tready),
    .m_axis_rslt_tdata  (m_axis_rslt_tdata),
    .m_axis_rslt_tlast  (m_axis_rslt_tlast),
    .m_axis_rslt_tvalid (m_axis_rslt_tvalid),
    .m_axis_rslt_tready (m_axis_rslt_tready),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lut_beats = 0;

  logic [16:0] lane_q [4][$];   // {last, data} per requester
  logic [16:0] lut_q [$];       // beats held inside the LUT model
  logic [20:0] exp_lut [$];     // {lane, last, data} expected at the LUT input
  logic [20:0] exp_rslt [$];    // {lane, last, data} expected at the result outputs
  logic [3:0]  lane_en = 4'hF;
  logic        lut_out_en = 1'b1;
  logic        bubble_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 4'd0;
      4'b0010: return 4'd1;
      4'b0100: return 4'd2;
      4'b1000: return 4'd3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic bit drained();
    return exp_lut.size() == 0 && exp_rslt.size() == 0 && lut_q.size() == 0 &&
           lane_q[0].size() == 0 && lane_q[1].size() == 0 &&
           lane_q[2].size() == 0 && lane_q[3].size() == 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int lane, input logic [15:0] base, input int n);
    for (int b = 0; b < n; b++) lane_q[lane].push_back({(b == n - 1), base + 16'(b)});
  endtask

  task automatic expect_pkt(input int lane, input logic [15:0] base, input int n);
    logic [15:0] d;
    for (int b = 0; b < n; b++) begin
      d = base + 16'(b);
      exp_lut.push_back({4'(lane), (b == n - 1), d});
      exp_rslt.push_back({4'(lane), (b == n - 1), ~d});
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!drained() && n < 300) begin
      step();
      n++;
    end
    n_tests++;
    if (!drained()) begin
      n_fail++;
      $display("FAIL drain_%s: %0d LUT beats and %0d results still expected, required 0",
               name, exp_lut.size(), exp_rslt.size());
    end
  endtask

  task automatic wait_lut_hs(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = m_axis_lut_tvalid && m_axis_lut_tready;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL hs_%s: no LUT handshake within 50 cycles, required one", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Requester drivers and LUT model: handshakes observed at negedge, new values driven after posedge.
  initial begin : drv
    forever begin
      @(negedge clk);
      if (rst) begin
        lut_q.delete();
      end else begin
        for (int k = 0; k < 4; k++)
          if (s_axis_req_tvalid[k] && s_axis_req_tready[k]) void'(lane_q[k].pop_front());
        if (m_axis_lut_tvalid && m_axis_lut_tready)
          lut_q.push_back({m_axis_lut_tlast, m_axis_lut_tdata});
        if (s_axis_lut_tvalid && s_axis_lut_tready) void'(lut_q.pop_front());
      end
      @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        s_axis_req_tvalid[k] = lane_en[k] && (lane_q[k].size() > 0);
        if (lane_q[k].size() > 0) begin
          s_axis_req_tdata[k*DW +: DW] = lane_q[k][0][15:0];
          s_axis_req_tlast[k]          = lane_q[k][0][16];
        end else begin
          s_axis_req_tlast[k] = 1'b0;
        end
      end
      s_axis_lut_tvalid = lut_out_en && (lut_q.size() > 0);
      if (lut_q.size() > 0) begin
        s_axis_lut_tdata = ~lut_q[0][15:0];
        s_axis_lut_tlast = lut_q[0][16];
      end else begin
        s_axis_lut_tlast = 1'b0;
      end
    end
  end

  // Monitor for beats entering the LUT: grant lane, data, last and inter-packet spacing.
  initial begin : mon_lut
    logic [20:0] e;
    logic [3:0]  lane;
    bit          have_prev;
    bit          prev_last;
    int          prev_cyc;
    int          gap;
    have_prev = 1'b0;
    prev_last = 1'b0;
    prev_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!bubble_chk) have_prev = 1'b0;
      if (!rst && m_axis_lut_tvalid && m_axis_lut_tready) begin
        lut_beats++;
        lane = onehot_idx(s_axis_req_tready);
        n_tests++;
        if (exp_lut.size() == 0) begin
          n_fail++;
          $display("FAIL lut_beat: unexpected beat lane %0d data %h, required none", lane, m_axis_lut_tdata);
        end else begin
          e = exp_lut.pop_front();
          if ({lane, m_axis_lut_tlast, m_axis_lut_tdata} !== e) begin
            n_fail++;
            $display("FAIL lut_beat: got lane %0d last %b data %h, required lane %0d last %b data %h",
                     lane, m_axis_lut_tlast, m_axis_lut_tdata, e[20:17], e[16], e[15:0]);
          end
        end
        if (bubble_chk && have_prev) begin
          gap = prev_last ? 2 : 1;
          n_tests++;
          if (cyc - prev_cyc != gap) begin
            n_fail++;
            $display("FAIL beat_spacing: got %0d cycles, required %0d", cyc - prev_cyc, gap);
          end
        end
        have_prev = 1'b1;
        prev_cyc  = cyc;
        prev_last = m_axis_lut_tlast;
      end
    end
  end

  // Monitor for results delivered to requester lanes.
  initial begin : mon_rslt
    logic [20:0] e;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          if (m_axis_rslt_tvalid[k] && m_axis_rslt_tready[k]) begin
            d = m_axis_rslt_tdata[k*DW +: DW];
            n_tests++;
            if (exp_rslt.size() == 0) begin
              n_fail++;
              $display("FAIL rslt_beat: unexpected result lane %0d data %h, required none", k, d);
            end else begin
              e = exp_rslt.pop_front();
              if ({4'(k), m_axis_rslt_tlast[k], d} !== e) begin
                n_fail++;
                $display("FAIL rslt_beat: got lane %0d last %b data %h, required lane %0d last %b data %h",
                         k, m_axis_rslt_tlast[k], d, e[20:17], e[16], e[15:0]);
              end
            end
          end
        end
      end
    end
  end

  initial begin : test
    int start;

    // Reset with every requester holding 2-beat packets; then round robin 0,1,2,3,0,1,2,3.
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++) begin
        send_pkt(k, 16'((k + 1) << 12) | 16'(p << 4), 2);
        expect_pkt(k, 16'((k + 1) << 12) | 16'(p << 4), 2);
      end
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_tready", 32'(s_axis_req_tready), 32'h0);
      chk("rst_lut_tvalid", 32'(m_axis_lut_tvalid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_rslt_tvalid", 32'(m_axis_rslt_tvalid), 32'h0);
      chk("rst_lut_tready", 32'(s_axis_lut_tready), 32'h0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("grant_latency_idle", 32'(s_axis_req_tready), 32'h0);
    @(negedge clk);
    chk("first_grant_req0", 32'(s_axis_req_tready), 32'h1);
    chk("first_grant_lut_tvalid", 32'(m_axis_lut_tvalid), 32'h1);
    wait_drain("round_robin");
    bubble_chk = 1'b0;

    // Sparse: requester 1 alone moves rr_ptr to 2, then 1 and 3 together give 3 before 1.
    step();
    send_pkt(1, 16'h0100, 1);
    expect_pkt(1, 16'h0100, 1);
    wait_drain("sparse_setup");
    send_pkt(3, 16'h0040, 2);
    send_pkt(1, 16'h0042, 2);
    expect_pkt(3, 16'h0040, 2);
    expect_pkt(1, 16'h0042, 2);
    wait_drain("sparse");

    // Route FIFO full: results held, only four packets may be issued.
    m_axis_rslt_tready = 4'h0;
    start = lut_beats;
    for (int p = 0; p < 6; p++) begin
      send_pkt(0, 16'h3000 + 16'(p), 1);
      expect_pkt(0, 16'h3000 + 16'(p), 1);
    end
    repeat (30) step();
    @(negedge clk);
    chk("full_issued", 32'(lut_beats - start), 32'd4);
    chk("full_lut_tvalid", 32'(m_axis_lut_tvalid), 32'h0);
    chk("full_req_tready", 32'(s_axis_req_tready), 32'h0);
    chk("full_busy", 32'(busy), 32'h1);
    chk("full_lut_stalled", 32'({s_axis_lut_tvalid, s_axis_lut_tready}), 32'h2);
    @(posedge clk);
    #1;
    m_axis_rslt_tready = 4'hF;
    @(negedge clk);
    chk("full_pop_now", 32'(s_axis_lut_tready), 32'h1);
    chk("full_pop_cycle_idle", 32'(m_axis_lut_tvalid), 32'h0);
    @(negedge clk);
    chk("full_push_blocked", 32'(m_axis_lut_tvalid), 32'h0);
    @(negedge clk);
    chk("full_issue_resumes", 32'(m_axis_lut_tvalid), 32'h1);
    chk("full_resume_grant", 32'(s_axis_req_tready), 32'h1);
    wait_drain("route_full");

    // Backpressure on lane 2 while it owns the FIFO head; lane 3's results wait behind it.
    step();
    m_axis_rslt_tready = 4'b1011;
    start = lut_beats;
    send_pkt(2, 16'h0200, 2);
    send_pkt(3, 16'h0300, 2);
    expect_pkt(2, 16'h0200, 2);
    expect_pkt(3, 16'h0300, 2);
    repeat (15) step();
    @(negedge clk);
    chk("bp_issued", 32'(lut_beats - start), 32'd4);
    chk("bp_lut_tvalid", 32'(s_axis_lut_tvalid), 32'h1);
    chk("bp_lut_tready", 32'(s_axis_lut_tready), 32'h0);
    chk("bp_rslt_tvalid", 32'(m_axis_rslt_tvalid), 32'b0100);
    @(posedge clk);
    #1;
    m_axis_rslt_tready = 4'hF;
    wait_drain("backpressure");

    // Requester 1 stalls mid-packet: grant must hold although 0 and 2 are requesting.
    step();
    start = lut_beats;
    send_pkt(1, 16'h0110, 3);
    expect_pkt(1, 16'h0110, 3);
    wait_lut_hs("stall_first_beat");
    lane_en[1] = 1'b0;
    send_pkt(0, 16'h0500, 1);
    send_pkt(2, 16'h0600, 1);
    expect_pkt(2, 16'h0600, 1);
    expect_pkt(0, 16'h0500, 1);
    repeat (5) step();
    @(negedge clk);
    chk("stall_beats", 32'(lut_beats - start), 32'd1);
    chk("stall_lut_tvalid", 32'(m_axis_lut_tvalid), 32'h0);
    chk("stall_grant_held", 32'(s_axis_req_tready), 32'b0010);
    @(posedge clk);
    #1;
    lane_en = 4'hF;
    wait_drain("stall");

    // Reset during BUSY: FIFO and rr_ptr cleared, next grant starts from requester 0.
    step();
    lut_out_en = 1'b0;
    send_pkt(2, 16'h0700, 3);
    expect_pkt(2, 16'h0700, 3);
    wait_lut_hs("reset_busy");
    rst = 1'b1;
    for (int k = 0; k < 4; k++) lane_q[k].delete();
    exp_lut.delete();
    exp_rslt.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_req_tready", 32'(s_axis_req_tready), 32'h0);
    chk("mid_rst_lut_tvalid", 32'(m_axis_lut_tvalid), 32'h0);
    chk("mid_rst_lut_tready", 32'(s_axis_lut_tready), 32'h0);
    @(posedge clk);
    #1;
    lut_out_en = 1'b1;
    send_pkt(3, 16'h0800, 1);
    send_pkt(0, 16'h0900, 1);
    expect_pkt(0, 16'h0900, 1);
    expect_pkt(3, 16'h0800, 1);
    wait_drain("after_reset");

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
